// File: rtl/pixie_pkg.sv
// Shared types and defaults for the Pixie scan doubler: line buffer geometry and
// the per-pixel entry stored in the line RAM.
package pixie_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 9;
  localparam int unsigned DEPTH_DEFAULT  = 1 << ADDR_W_DEFAULT;

  typedef struct packed {
    logic hblank;
    logic video;
  } entry_t;

endpackage

// File: rtl/pixie_scandoubler_if.sv
// Pixel-rate input timing from the back end and doubled-rate video toward the display.
interface pixie_scandoubler_if;
  logic ce_pix;
  logic video_in;
  logic hsync_in;
  logic vsync_in;
  logic hblank_in;
  logic vblank_in;
  logic video_out;
  logic hsync_out;
  logic vsync_out;
  logic hblank_out;
  logic vblank_out;
  logic de_out;

  modport master (
    output ce_pix, video_in, hsync_in, vsync_in, hblank_in, vblank_in,
    input  video_out, hsync_out, vsync_out, hblank_out, vblank_out, de_out
  );

  modport slave (
    input  ce_pix, video_in, hsync_in, vsync_in, hblank_in, vblank_in,
    output video_out, hsync_out, vsync_out, hblank_out, vblank_out, de_out
  );
endinterface

// File: rtl/pixie_sd_line_ram.sv
// Ping-pong line buffer: two banks of DEPTH entries, one write port and one
// registered read port returning the old word on a same-address collision.
module pixie_sd_line_ram
  import pixie_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              we,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  entry_t            wr_data,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output entry_t            rd_data
);
  localparam int unsigned Words = 2 << ADDR_W;

  entry_t mem [Words];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
    rd_data <= mem[{rd_bank, rd_addr}];
  end
endmodule

// File: rtl/pixie_scandoubler.sv
// Line doubler: buffers each pixel-rate input line and replays it twice at full clock
// rate, regenerating sync and blanking from the measured input line timing.
module pixie_scandoubler
  import pixie_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input logic                clk,
  input logic                reset,
  pixie_scandoubler_if.slave vid
);
  localparam logic [ADDR_W:0] LenOne = {{ADDR_W{1'b0}}, 1'b1};

  logic              hs_prev, vs_s, vb_s;
  logic              wr_bank, seen_rise, line_valid;
  logic              out_valid, hsync_q, vsync_q, vblank_q;
  logic [ADDR_W:0]   in_x, line_len, hs_cnt, hs_len;
  logic [ADDR_W:0]   eff_len, out_x_inc;
  logic [ADDR_W-1:0] out_x, out_x_d, wr_addr;
  logic              hs_rise, wr_sel, hblank_o;
  entry_t            wr_data, rd_data;

  always_comb begin
    hs_rise   = vid.ce_pix & vid.hsync_in & ~hs_prev;
    wr_sel    = hs_rise ? ~wr_bank : wr_bank;
    // in_x counts ticks up to DEPTH; the address sticks at the last entry
    wr_addr   = hs_rise ? '0 : (in_x[ADDR_W] ? '1 : in_x[ADDR_W-1:0]);
    wr_data   = {vid.hblank_in, vid.video_in};
    eff_len   = (line_len == '0) ? LenOne : line_len;
    out_x_inc = {1'b0, out_x} + LenOne;
    out_x_d   = (hs_rise || (out_x_inc >= eff_len)) ? '0 : out_x_inc[ADDR_W-1:0];
  end

  pixie_sd_line_ram #(
    .ADDR_W (ADDR_W)
  ) u_line_ram (
    .clk     (clk),
    .we      (vid.ce_pix),
    .wr_bank (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_bank (~wr_bank),
    .rd_addr (out_x),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_prev    <= 1'b0;
      vs_s       <= 1'b0;
      vb_s       <= 1'b0;
      in_x       <= '0;
      wr_bank    <= 1'b0;
      line_len   <= '0;
      hs_cnt     <= '0;
      hs_len     <= '0;
      seen_rise  <= 1'b0;
      line_valid <= 1'b0;
    end else if (vid.ce_pix) begin
      hs_prev <= vid.hsync_in;
      vs_s    <= vid.vsync_in;
      vb_s    <= vid.vblank_in;
      if (hs_rise) begin
        wr_bank   <= ~wr_bank;
        line_len  <= in_x;
        in_x      <= LenOne;
        hs_cnt    <= LenOne;
        seen_rise <= 1'b1;
        if (seen_rise) begin
          line_valid <= 1'b1;
        end
      end else begin
        if (!in_x[ADDR_W]) begin
          in_x <= in_x + LenOne;
        end
        if (vid.hsync_in && hs_prev && !hs_cnt[ADDR_W]) begin
          hs_cnt <= hs_cnt + LenOne;
        end
        if (!vid.hsync_in && hs_prev) begin
          hs_len <= hs_cnt;
        end
      end
    end
  end

  // Output registers line up with the RAM read data, one clock after out_x.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_x     <= '0;
      out_valid <= 1'b0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      vblank_q  <= 1'b1;
    end else begin
      out_x     <= out_x_d;
      out_valid <= line_valid;
      hsync_q   <= line_valid & ({1'b0, out_x} < hs_len);
      if (out_x == '0) begin
        vsync_q  <= line_valid & vs_s;
        vblank_q <= ~line_valid | vb_s;
      end
    end
  end

  assign hblank_o       = rd_data.hblank | ~out_valid;
  assign vid.video_out  = rd_data.video & out_valid;
  assign vid.hblank_out = hblank_o;
  assign vid.hsync_out  = hsync_q;
  assign vid.vsync_out  = vsync_q;
  assign vid.vblank_out = vblank_q;
  assign vid.de_out     = ~hblank_o & ~vblank_q & out_valid;
endmodule
